// File: rtl/peripheral_msi_slave_port_axi4_if.sv
// AHB-Lite slave-side bus bundle for one slave port.
// Ports: master modport drives address/data/HREADY, slave modport returns HREADYOUT.
interface peripheral_msi_slave_port_axi4_if #(
   parameter int PLEN = 64,
   parameter int XLEN = 64
);
   logic            slv_HSEL;
   logic [PLEN-1:0] slv_HADDR;
   logic [XLEN-1:0] slv_HWDATA;
   logic            slv_HWRITE;
   logic [2:0]      slv_HSIZE;
   logic [2:0]      slv_HBURST;
   logic [3:0]      slv_HPROT;
   logic [1:0]      slv_HTRANS;
   logic            slv_HMASTLOCK;
   logic            slv_HREADY;
   logic            slv_HREADYOUT;

   modport master (
      output slv_HSEL, slv_HADDR, slv_HWDATA, slv_HWRITE,
      output slv_HSIZE, slv_HBURST, slv_HPROT, slv_HTRANS,
      output slv_HMASTLOCK, slv_HREADY,
      input  slv_HREADYOUT
   );

   modport slave (
      input  slv_HSEL, slv_HADDR, slv_HWDATA, slv_HWRITE,
      input  slv_HSIZE, slv_HBURST, slv_HPROT, slv_HTRANS,
      input  slv_HMASTLOCK, slv_HREADY,
      output slv_HREADYOUT
   );
endinterface

// File: rtl/peripheral_msi_slave_port_axi4.sv
// Per-slave arbiter/mux: picks one master by priority, drives the AHB-Lite slave.
// Ports: HCLK/HRESET, mst_* request arrays, can_switch, master_granted,
// slv (bus bundle to the slave). Macro MSI_SLAVE_PORT_RR_EN enables round-robin ties.
module peripheral_msi_slave_port_axi4 #(
   parameter int PLEN    = 64,
   parameter int XLEN    = 64,
   parameter int MASTERS = 5,
   parameter int SLAVES  = 5
) (
   input  logic                           HRESET,
   input  logic                           HCLK,
   input  logic [MASTERS-1:0][2:0]        mst_priority,
   input  logic [MASTERS-1:0]             mst_HSEL,
   input  logic [MASTERS-1:0][PLEN-1:0]   mst_HADDR,
   input  logic [MASTERS-1:0][XLEN-1:0]   mst_HWDATA,
   input  logic [MASTERS-1:0]             mst_HWRITE,
   input  logic [MASTERS-1:0][2:0]        mst_HSIZE,
   input  logic [MASTERS-1:0][2:0]        mst_HBURST,
   input  logic [MASTERS-1:0][3:0]        mst_HPROT,
   input  logic [MASTERS-1:0][1:0]        mst_HTRANS,
   input  logic [MASTERS-1:0]             mst_HMASTLOCK,
   input  logic [MASTERS-1:0]             mst_HREADY,
   input  logic [MASTERS-1:0]             can_switch,
   output logic [MASTERS-1:0]             master_granted,
   peripheral_msi_slave_port_axi4_if.master slv
);
   localparam int IW = (MASTERS > 1) ? $clog2(MASTERS) : 1;

   typedef enum logic [1:0] {IDLE, GRANTED, LOCKED} state_t;

   state_t             state, state_n;
   logic [IW-1:0]      own_idx, own_idx_n;
   logic [IW-1:0]      data_idx, win;
   logic [MASTERS-1:0] gnt_n;
   logic               data_valid;
   logic               owned, any_req, switch_pt, grant_ev;
   logic [2:0]         best;
   logic               found;
   logic               unused_ok;

   assign owned     = (state != IDLE);
   assign any_req   = |mst_HSEL;
   assign switch_pt = can_switch[own_idx] & slv.slv_HREADYOUT;

`ifdef MSI_SLAVE_PORT_RR_EN
   logic [IW-1:0] rr_ptr;

   // Scan starts at rr_ptr; strict '>' keeps the first equal-priority
   // index in rotation order, so the owner loses ties.
   always_comb begin
      int idx;
      idx   = 0;
      win   = '0;
      best  = '0;
      found = 1'b0;
      for (int k = 0; k < MASTERS; k++) begin
         idx = int'(rr_ptr) + k;
         if (idx >= MASTERS) idx = idx - MASTERS;
         if (mst_HSEL[idx] && (!found || mst_priority[idx] > best)) begin
            found = 1'b1;
            best  = mst_priority[idx];
            win   = IW'(idx);
         end
      end
   end

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET)
         rr_ptr <= '0;
      else if (grant_ev)
         rr_ptr <= (win == IW'(MASTERS-1)) ? '0 : win + 1'b1;
   end
`else
   // Seeding with the owner makes it keep the bus on ties;
   // otherwise the lowest index wins ties.
   always_comb begin
      win   = '0;
      best  = '0;
      found = 1'b0;
      if (owned && mst_HSEL[own_idx]) begin
         found = 1'b1;
         best  = mst_priority[own_idx];
         win   = own_idx;
      end
      for (int i = 0; i < MASTERS; i++) begin
         if (mst_HSEL[i] && (!found || mst_priority[i] > best)) begin
            found = 1'b1;
            best  = mst_priority[i];
            win   = IW'(i);
         end
      end
   end
`endif

   always_comb begin
      state_n   = state;
      own_idx_n = own_idx;
      gnt_n     = master_granted;
      grant_ev  = 1'b0;
      unique case (state)
         IDLE: begin
            if (any_req) grant_ev = 1'b1;
         end
         GRANTED: begin
            if (switch_pt) begin
               if (any_req) begin
                  grant_ev = 1'b1;
               end else begin
                  state_n = IDLE;
                  gnt_n   = '0;
               end
            end
         end
         LOCKED: begin
            if (!mst_HMASTLOCK[own_idx]) state_n = GRANTED;
         end
         default: state_n = IDLE;
      endcase
      if (grant_ev) begin
         own_idx_n  = win;
         gnt_n      = '0;
         gnt_n[win] = 1'b1;
         state_n    = mst_HMASTLOCK[win] ? LOCKED : GRANTED;
      end
   end

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         state          <= IDLE;
         own_idx        <= '0;
         master_granted <= '0;
         data_idx       <= '0;
         data_valid     <= 1'b0;
      end else begin
         state          <= state_n;
         own_idx        <= own_idx_n;
         master_granted <= gnt_n;
         // Data-phase owner only advances when the slave accepts,
         // so a grant change never steals an in-flight HWDATA.
         if (slv.slv_HREADYOUT) begin
            data_idx   <= own_idx;
            data_valid <= slv.slv_HSEL && (slv.slv_HTRANS != 2'b00);
         end
      end
   end

   always_comb begin
      slv.slv_HSEL      = 1'b0;
      slv.slv_HADDR     = '0;
      slv.slv_HWRITE    = 1'b0;
      slv.slv_HSIZE     = '0;
      slv.slv_HBURST    = '0;
      slv.slv_HPROT     = '0;
      slv.slv_HTRANS    = 2'b00;
      slv.slv_HMASTLOCK = 1'b0;
      slv.slv_HREADY    = 1'b1;
      if (owned) begin
         slv.slv_HSEL      = mst_HSEL[own_idx];
         slv.slv_HADDR     = mst_HADDR[own_idx];
         slv.slv_HWRITE    = mst_HWRITE[own_idx];
         slv.slv_HSIZE     = mst_HSIZE[own_idx];
         slv.slv_HBURST    = mst_HBURST[own_idx];
         slv.slv_HPROT     = mst_HPROT[own_idx];
         slv.slv_HTRANS    = mst_HTRANS[own_idx];
         slv.slv_HMASTLOCK = mst_HMASTLOCK[own_idx];
         slv.slv_HREADY    = mst_HREADY[own_idx];
      end
   end

   assign slv.slv_HWDATA = mst_HWDATA[data_idx];

   // data_valid is tracked for observation only; SLAVES is informational.
   assign unused_ok = data_valid & (SLAVES > 0);
endmodule

// File: tb/tb_peripheral_msi_slave_port_axi4.sv
// Scoreboard bench for peripheral_msi_slave_port_axi4.
// Driver pushes reference-model expectations; a negedge monitor compares.
module tb_peripheral_msi_slave_port_axi4;
   localparam int M  = 5;
   localparam int PL = 64;
   localparam int XL = 64;

   logic                   HCLK = 1'b0;
   logic                   HRESET;
   logic [M-1:0][2:0]      prio;
   logic [M-1:0]           sel, wr, mlock, mready, cansw;
   logic [M-1:0][PL-1:0]   addr;
   logic [M-1:0][XL-1:0]   wdata;
   logic [M-1:0][2:0]      size, burst;
   logic [M-1:0][3:0]      prot;
   logic [M-1:0][1:0]      trans;
   logic [M-1:0]           gnt;
   logic                   hro;

   peripheral_msi_slave_port_axi4_if #(.PLEN(PL), .XLEN(XL)) bus ();

   assign bus.slv_HREADYOUT = hro;

   peripheral_msi_slave_port_axi4 #(
      .PLEN(PL), .XLEN(XL), .MASTERS(M), .SLAVES(5)
   ) dut (
      .HRESET        (HRESET),
      .HCLK          (HCLK),
      .mst_priority  (prio),
      .mst_HSEL      (sel),
      .mst_HADDR     (addr),
      .mst_HWDATA    (wdata),
      .mst_HWRITE    (wr),
      .mst_HSIZE     (size),
      .mst_HBURST    (burst),
      .mst_HPROT     (prot),
      .mst_HTRANS    (trans),
      .mst_HMASTLOCK (mlock),
      .mst_HREADY    (mready),
      .can_switch    (cansw),
      .master_granted(gnt),
      .slv           (bus)
   );

   always #5 HCLK = ~HCLK;

   typedef struct {
      logic [M-1:0]  gnt;
      logic          hsel;
      logic [PL-1:0] haddr;
      logic [1:0]    htrans;
      logic          hready;
      logic [XL-1:0] hwdata;
      logic [11:0]   misc;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   // Reference model: owner index (valid flag), lock flag, data owner, rr pointer.
   int m_idx, m_didx, m_rr;
   bit m_valid, m_lock;

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_idx = 0; m_didx = 0; m_rr = 0;
      m_valid = 0; m_lock = 0;
   endtask

   function automatic int pick();
      int best, i;
      best = -1;
      for (int k = 0; k < M; k++) begin
`ifdef MSI_SLAVE_PORT_RR_EN
         i = (m_rr + k) % M;
`else
         i = k;
`endif
         if (sel[i] && (best < 0 || prio[i] > prio[best])) best = i;
      end
`ifndef MSI_SLAVE_PORT_RR_EN
      if (m_valid && sel[m_idx] && prio[m_idx] >= prio[best]) best = m_idx;
`endif
      return best;
   endfunction

   task automatic model_step();
      int w;
      bit g;
      if (HRESET) begin
         model_reset();
         return;
      end
      if (hro) m_didx = m_idx;
      g = 0;
      if (!m_valid) g = (sel != 0);
      else if (m_lock) begin
         if (!mlock[m_idx]) m_lock = 0;
      end else if (cansw[m_idx] && hro) begin
         if (sel != 0) g = 1;
         else m_valid = 0;
      end
      if (g) begin
         w = pick();
         m_idx = w; m_valid = 1;
         m_lock = mlock[w];
         m_rr = (w + 1) % M;
      end
   endtask

   task automatic push_exp();
      exp_t e;
      e.gnt = '0;
      if (m_valid) e.gnt[m_idx] = 1'b1;
      e.hsel   = m_valid ? sel[m_idx] : 1'b0;
      e.haddr  = m_valid ? addr[m_idx] : '0;
      e.htrans = m_valid ? trans[m_idx] : 2'b00;
      e.hready = m_valid ? mready[m_idx] : 1'b1;
      e.hwdata = wdata[m_didx];
      e.misc   = m_valid ? {wr[m_idx], size[m_idx], burst[m_idx],
                            prot[m_idx], mlock[m_idx]} : '0;
      q.push_back(e);
   endtask

   // One cycle: expectation for the current window, then edge, then model.
   task automatic step();
      push_exp();
      @(posedge HCLK);
      #1;
      model_step();
   endtask

   task automatic clr();
      sel = '0; prio = '0; wr = '0; mlock = '0;
      mready = '1; cansw = '1; hro = 1'b1;
      addr = '0; size = '0; burst = '0; prot = '0; trans = '0;
      for (int i = 0; i < M; i++) wdata[i] = 64'hDA7A_0000_0000_0000 | 64'(i);
   endtask

   task automatic do_reset();
      HRESET = 1'b1;
      model_reset();
      #1;
      chk("rst_gnt", 64'(gnt), 64'd0);
      chk("rst_htrans", 64'(bus.slv_HTRANS), 64'd0);
      chk("rst_hready", 64'(bus.slv_HREADY), 64'd1);
      step();
      HRESET = 1'b0;
   endtask

   task automatic randomize_inputs();
      for (int i = 0; i < M; i++) begin
         sel[i]    = ($urandom_range(0, 99) < 45);
         prio[i]   = 3'($urandom_range(0, 3));
         wr[i]     = 1'($urandom);
         mlock[i]  = ($urandom_range(0, 99) < 12);
         mready[i] = 1'($urandom);
         cansw[i]  = ($urandom_range(0, 99) < 70);
         addr[i]   = {$urandom, $urandom};
         wdata[i]  = {$urandom, $urandom};
         size[i]   = 3'($urandom);
         burst[i]  = 3'($urandom);
         prot[i]   = 4'($urandom);
         trans[i]  = 2'($urandom);
      end
      hro = ($urandom_range(0, 99) < 75);
   endtask

   always @(negedge HCLK) begin : monitor
      exp_t e;
      if (q.size() > 0) begin
         e = q.pop_front();
         chk("gnt", 64'(gnt), 64'(e.gnt));
         chk("hsel", 64'(bus.slv_HSEL), 64'(e.hsel));
         chk("haddr", bus.slv_HADDR, e.haddr);
         chk("htrans", 64'(bus.slv_HTRANS), 64'(e.htrans));
         chk("hready", 64'(bus.slv_HREADY), 64'(e.hready));
         chk("hwdata", bus.slv_HWDATA, e.hwdata);
         chk("misc", 64'({bus.slv_HWRITE, bus.slv_HSIZE, bus.slv_HBURST,
                          bus.slv_HPROT, bus.slv_HMASTLOCK}), 64'(e.misc));
      end
   end

   initial begin
      clr();
      HRESET = 1'b1;
      model_reset();
      @(posedge HCLK);
      #1;
      step();
      chk("reset_gnt", 64'(gnt), 64'd0);
      HRESET = 1'b0;

      // single request
      sel[2] = 1'b1; trans[2] = 2'b10; addr[2] = 64'h1000;
      step();
      chk("single_gnt", 64'(gnt), 64'h04);
      chk("single_haddr", bus.slv_HADDR, 64'h1000);
      chk("single_hsel", 64'(bus.slv_HSEL), 64'd1);
      clr();
      step();

      // priority from idle, then hand-over on release
      sel[1] = 1'b1; prio[1] = 3'd3;
      sel[4] = 1'b1; prio[4] = 3'd6;
      step();
      chk("prio_gnt4", 64'(gnt), 64'h10);
      sel[4] = 1'b0;
      step();
      chk("prio_gnt1", 64'(gnt), 64'h02);
      clr();
      step();

      // lock holds against a higher-priority requester
      sel[0] = 1'b1; mlock[0] = 1'b1;
      step();
      sel[3] = 1'b1; prio[3] = 3'd7;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("lock_hold", 64'(gnt), 64'h01);
      end
      mlock[0] = 1'b0;
      step();
      chk("unlock_gnt", 64'(gnt), 64'h01);
      step();
      chk("after_lock", 64'(gnt), 64'h08);
      clr();
      step();

      // data-phase owner survives a grant change
      sel[0] = 1'b1; wr[0] = 1'b1; trans[0] = 2'b10;
      step();
      sel[1] = 1'b1; prio[1] = 3'd5; trans[1] = 2'b10;
      step();
      hro = 1'b0;
      #1;
      chk("dphase_keep", bus.slv_HWDATA, wdata[0]);
      step();
      chk("dphase_keep2", bus.slv_HWDATA, wdata[0]);
      hro = 1'b1;
      step();
      chk("dphase_new", bus.slv_HWDATA, wdata[1]);

      // wait states block switching
      sel[0] = 1'b0;
      sel[2] = 1'b1; prio[2] = 3'd7; hro = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("wait_hold", 64'(gnt), 64'h02);
      end
      hro = 1'b1;
      step();
      chk("wait_switch", 64'(gnt), 64'h04);

      // reset mid-burst
      do_reset();

`ifdef MSI_SLAVE_PORT_RR_EN
      clr();
      sel[0] = 1'b1; sel[1] = 1'b1; sel[2] = 1'b1;
      step();
      chk("rr_0", 64'(gnt), 64'h01);
      step();
      chk("rr_1", 64'(gnt), 64'h02);
      step();
      chk("rr_2", 64'(gnt), 64'h04);
      step();
      chk("rr_3", 64'(gnt), 64'h01);
`endif

      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 299) == 0) begin
            do_reset();
         end else begin
            randomize_inputs();
            step();
         end
      end

      for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge HCLK);
      #1;
      chk("drain", 64'(q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
